ms_generator: RTL

Mine-field generator for the 8x8 minesweeper board. It is the responder side of the gen_reset/gen_done handshake driven by ms_controller. On each request it clears the board and places exactly MINES mines at pseudo-random distinct cells, using a free-running LFSR. It then presents the 64-bit mine map and holds gen_done until the next request.

---
 rtl/ms_generator.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ms_generator.sv
// ----------------------------------------------------------------------------
// ms_generator
//
// Mine-field generator for the 8x8 minesweeper board. It answers the
// gen_reset/gen_done handshake from ms_controller. Each request clears the
// board, then drops exactly MINES mines on distinct cells chosen by a
// free-running 16-bit LFSR. If random placement runs out of its cycle budget,
// it fills the lowest free cells in order. The finished map is held with
// gen_done high until the next request.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-low reset
//   gen_reset  generation request, sampled every cycle
//   gen_done   registered, high while the mine map is complete and stable
//   mine       64-bit mine map, bit i = cell i (row i[5:3], col i[2:0])
//   placed     number of mines currently set in mine
// ----------------------------------------------------------------------------
module ms_generator #(
   parameter int          MINES   = 10,
   parameter logic [15:0] SEED    = 16'hACE1,
   parameter int          TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        gen_reset,
   output logic        gen_done,
   output logic [63:0] mine,
   output logic [6:0]  placed
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      PLACE,
      FILL,
      DONE
   } state_t;

   localparam logic [6:0] MINES_L      = 7'(MINES);
   localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);

   state_t      state;
   logic [15:0] lfsr;
   logic [15:0] lfsr_next;
   logic [9:0]  timeout;
   logic [5:0]  idx;
   logic [5:0]  pos;
   logic        fb;
   logic        pos_free;
   logic        idx_free;
   logic [6:0]  placed_inc;

   // Fibonacci LFSR for x^16+x^14+x^13+x^11+1. An all-zero register would
   // stick forever, so it is forced back to a nonzero value.
   assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_comb begin
      lfsr_next = {lfsr[14:0], fb};
      if (lfsr == 16'h0000) begin
         lfsr_next = 16'h0001;
      end
   end

   // The candidate cell comes from the register value before this cycle's
   // shift. The FILL scan looks at cell idx.
   assign pos        = lfsr[5:0];
   assign pos_free   = ~mine[pos];
   assign idx_free   = ~mine[idx];
   assign placed_inc = placed + 7'd1;

   // Main sequencer. The LFSR shifts every cycle in every state so that the
   // player's request timing feeds into the board layout. gen_done is
   // registered. It is set on the edge that enters DONE and cleared on the
   // edge that samples a request, so the controller never sees a stale done.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         mine     <= '0;
         placed   <= '0;
         gen_done <= 1'b0;
         lfsr     <= SEED;
         timeout  <= '0;
         idx      <= '0;
      end else begin
         lfsr <= lfsr_next;
         case (state)
            IDLE: begin
               gen_done <= 1'b0;
               if (gen_reset) begin
                  state <= CLEAR;
               end
            end

            CLEAR: begin
               mine     <= '0;
               placed   <= '0;
               timeout  <= '0;
               idx      <= '0;
               gen_done <= 1'b0;
               state    <= PLACE;
            end

            PLACE: begin
               if (gen_reset) begin
                  state <= CLEAR;
               end else begin
                  timeout <= timeout + 10'd1;
                  // A collision leaves the map alone. Completion takes
                  // priority over the timeout fallback on the same cycle.
                  if (pos_free) begin
                     mine[pos] <= 1'b1;
                     placed    <= placed_inc;
                  end
                  if (pos_free && placed_inc == MINES_L) begin
                     state    <= DONE;
                     gen_done <= 1'b1;
                  end else if (timeout == TIMEOUT_LAST) begin
                     state <= FILL;
                  end
               end
            end

            FILL: begin
               if (gen_reset) begin
                  state <= CLEAR;
               end else begin
                  idx <= idx + 6'd1;
                  // MINES is at most 63, so the scan always finishes
                  // before idx wraps.
                  if (idx_free) begin
                     mine[idx] <= 1'b1;
                     placed    <= placed_inc;
                     if (placed_inc == MINES_L) begin
                        state    <= DONE;
                        gen_done <= 1'b1;
                     end
                  end
               end
            end

            DONE: begin
               if (gen_reset) begin
                  state    <= CLEAR;
                  gen_done <= 1'b0;
               end else begin
                  gen_done <= 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               gen_done <= 1'b0;
            end
         endcase
      end
   end

endmodule
